bcd_seq_converter: RTL

- Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock.
- Successor to the team's combinational 8-bit hundreds/tens/ones converter. It supports any input width and digit count, a start/busy/done handshake, a registered result and overflow detection.
- Sits between counters or arithmetic blocks and the seven-segment display driver, where a wide combinational chain would not meet timing.

---
 rtl/bcd_seq_converter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/bcd_seq_converter.sv
//------------------------------------------------------------------------------
// Module      : bcd_seq_converter
// Description : Sequential binary-to-BCD converter (shift-and-add-3), one bit
//               per clock, with start/busy/done handshake and overflow flag.
//               Optional macro SIGNED_EN: two's complement input, sign on neg.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_seq_converter #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      binary,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic                  neg
);

    localparam int                 c_ACC_W    = 4 * DIGITS;
    localparam int                 c_CNT_W    = $clog2(BIN_W + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(BIN_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [BIN_W-1:0]     r_shift;
    logic [c_ACC_W-1:0]   r_acc;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_ovf;
    logic [c_ACC_W-1:0]   r_bcd;
    logic                 r_overflow;
    logic [c_ACC_W-1:0]   w_adj;
    logic [BIN_W-1:0]     w_mag;
    logic                 w_accept;
    logic                 w_publish;

    assign w_accept  = (r_state == S_IDLE) && start;
    // The counter reaches zero after the last shift; that cycle hands off the result.
    assign w_publish = (r_state == S_SHIFT) && (r_cnt == '0);

`ifdef SIGNED_EN
    logic w_sign;
    logic r_sign;
    logic r_neg;

    assign w_sign = binary[BIN_W-1];
    // The most negative value negates to itself, which is the correct unsigned magnitude.
    assign w_mag  = w_sign ? (BIN_W'(0) - binary) : binary;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sign <= 1'b0;
            r_neg  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sign <= w_sign;
            end
            if (w_publish) begin
                r_neg <= r_sign;
            end
        end
    end

    assign neg = r_neg;
`else
    assign w_mag = binary;
    assign neg   = 1'b0;
`endif

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_digit
            assign w_adj[4*k +: 4] = (r_acc[4*k +: 4] >= 4'd5) ? (r_acc[4*k +: 4] + 4'd3)
                                                                 : r_acc[4*k +: 4];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)        w_next = S_SHIFT;
            S_SHIFT: if (r_cnt == '0)  w_next = S_DONE;
            S_DONE:                    w_next = S_IDLE;
            default:                   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift    <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_bcd      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shift <= w_mag;
                r_acc   <= '0;
                r_ovf   <= 1'b0;
                r_cnt   <= c_CNT_INIT;
            end else if (r_state == S_SHIFT) begin
                if (r_cnt != '0) begin
                    r_acc   <= {w_adj[c_ACC_W-2:0], r_shift[BIN_W-1]};
                    r_shift <= r_shift << 1;
                    r_ovf   <= r_ovf | w_adj[c_ACC_W-1];
                    r_cnt   <= r_cnt - c_CNT_W'(1);
                end else begin
                    r_bcd      <= r_acc;
                    r_overflow <= r_ovf;
                end
            end
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign bcd      = r_bcd;
    assign overflow = r_overflow;

endmodule

`default_nettype wire
